// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Provides datapath widths, the PC increment, the NOP encoding and the
// prefetch-queue entry layout {pc_plus4, instr}.
package if_fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_INC  = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b0;

    // One prefetch-queue slot: address of the following instruction plus the word.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle.
//   imem_req   : fetch request this cycle (master -> memory)
//   imem_addr  : byte address of the request (master -> memory)
//   imem_gnt   : memory accepts the request this cycle (memory -> master)
//   imem_rdata : read data, valid the cycle after an accepted request
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// Prefetch FIFO with synchronous flush.
//   clk, rst        : clock, asynchronous active-low reset
//   flush           : empty the queue at this edge (overrides push/pop)
//   push, push_data : enqueue one entry
//   pop             : dequeue the head entry (ignored when empty)
//   count, empty    : occupancy
//   head            : current head entry (undefined content when empty)
module if_fetch_stage_fetch_queue
    import if_fetch_stage_pkg::*;
#(
    parameter  int unsigned FQ_DEPTH = 4,
    localparam int unsigned PTR_W    = $clog2(FQ_DEPTH),
    localparam int unsigned CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output fq_entry_t        head
);

    fq_entry_t        mem [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop & ~empty;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end.
// Owns the fetch PC, issues requests to a 1-cycle-latency instruction memory,
// buffers returned words in a prefetch queue and presents the head to decode.
//   clk, rst    : clock, asynchronous active-low reset
//   imem        : instruction-memory request/response (master side)
//   Br_taken    : branch redirect from execute (highest priority)
//   Br_addr     : redirect target
//   freeze      : decode stall; hold the current head
//   Instruction : head instruction (NOP when empty)
//   PC          : head instruction address + 4 (0 when empty)
//   inst_valid  : Instruction/PC are meaningful
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned       FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.master   imem,
    input  logic               Br_taken,
    input  logic [ADDR_W-1:0]  Br_addr,
    input  logic               freeze,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  PC,
    output logic               inst_valid
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic              pending;
    logic              kill;
    logic              accept;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  fq_count;
    logic              fq_empty;
    logic              fq_push;
    logic              fq_pop;
    fq_entry_t         fq_in;
    fq_entry_t         fq_head;

    // Words held plus the one in flight never exceed the queue depth.
    assign occ           = OCC_W'(fq_count) + OCC_W'(pending);
    assign imem.imem_req = rst & ~Br_taken & (occ < OCC_W'(FQ_DEPTH));
    assign imem.imem_addr = fetch_pc;
    assign accept        = imem.imem_req & imem.imem_gnt;

    // While a response is pending fetch_pc already equals its address + 4.
    assign fq_in.pc_plus4 = fetch_pc;
    assign fq_in.instr    = imem.imem_rdata;
    assign fq_push        = pending & ~kill & ~Br_taken;
    assign fq_pop         = ~fq_empty & ~freeze & ~Br_taken;

    assign inst_valid  = ~fq_empty;
    assign Instruction = fq_empty ? NOP_INSTR : fq_head.instr;
    assign PC          = fq_empty ? '0 : fq_head.pc_plus4;

    // Fetch PC, outstanding-response and stale-response tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= PC_RESET;
            pending  <= 1'b0;
            kill     <= 1'b0;
        end else if (Br_taken) begin
            fetch_pc <= Br_addr;
            pending  <= 1'b0;
            kill     <= pending | accept;
        end else begin
            if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            pending <= accept;
            kill    <= 1'b0;
        end
    end

    if_fetch_stage_fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (Br_taken),
        .push      (fq_push),
        .push_data (fq_in),
        .pop       (fq_pop),
        .count     (fq_count),
        .empty     (fq_empty),
        .head      (fq_head)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: startup, freeze, redirect, grant gaps,
// mid-stream reset and PC wrap. Memory word at address a is a ^ 32'hC0DE_0000.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam int unsigned FQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic        freeze;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        inst_valid;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .PC_RESET (32'h0000_0000),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .freeze      (freeze),
        .Instruction (Instruction),
        .PC          (PC),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memory: data appears the cycle after an accepted request.
    always @(posedge clk) begin
        if (imem.imem_req && imem.imem_gnt) imem.imem_rdata <= word(imem.imem_addr);
    end

    // The queue must never see a push while full.
    always @(negedge clk) begin
        if (rst && dut.fq_push) begin
            assert (int'(dut.fq_count) < FQ_DEPTH) else begin
                n_fail++;
                $error("FAIL overflow: count %0d at push, required below %0d", dut.fq_count, FQ_DEPTH);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; Br_taken = 1'b0; Br_addr = '0; freeze = 1'b0;
        imem.imem_gnt = 1'b0;
        #1;
        chk("rst_req",   32'(imem.imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pc",    PC, 32'h0);
        imem.imem_gnt = 1'b1;
        tick();
        chk("rst_req_gated", 32'(imem.imem_req), 32'h0);

        // Startup stream, grant always high
        rst = 1'b1;
        #1;
        chk("st_req0",  32'(imem.imem_req), 32'h1);
        chk("st_addr0", imem.imem_addr, 32'h0);
        tick();
        chk("st_addr1",  imem.imem_addr, 32'h4);
        chk("st_valid1", 32'(inst_valid), 32'h0);
        tick();
        chk("st_valid2", 32'(inst_valid), 32'h1);
        chk("st_instr2", Instruction, word(32'h0));
        chk("st_pc2",    PC, 32'h4);
        chk("st_addr2",  imem.imem_addr, 32'h8);
        tick();
        chk("st_instr3", Instruction, word(32'h4));
        chk("st_pc3",    PC, 32'h8);
        tick();
        chk("st_instr4", Instruction, word(32'h8));

        // Freeze for 10 edges with head = word(8)
        freeze = 1'b1;
        tick();
        chk("fz_instr5", Instruction, word(32'h8));
        chk("fz_req5",   32'(imem.imem_req), 32'h1);
        tick();
        chk("fz_req6",   32'(imem.imem_req), 32'h0);
        chk("fz_instr6", Instruction, word(32'h8));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fz_hold_instr", Instruction, word(32'h8));
            chk("fz_hold_pc",    PC, 32'hC);
            chk("fz_hold_req",   32'(imem.imem_req), 32'h0);
        end
        freeze = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fz_resume_instr", Instruction, word(32'(12 + 4 * k)));
            chk("fz_resume_pc",    PC, 32'(16 + 4 * k));
        end

        // Redirect with three queued words and one response in flight
        rst = 1'b0;
        tick();
        rst = 1'b1; freeze = 1'b1;
        tick(); tick(); tick();
        chk("br_req3", 32'(imem.imem_req), 32'h1);
        tick();
        chk("br_full_req",   32'(imem.imem_req), 32'h0);
        chk("br_full_instr", Instruction, word(32'h0));
        Br_taken = 1'b1; Br_addr = 32'h100; freeze = 1'b0;
        tick();
        Br_taken = 1'b0;
        #1;
        chk("br_t1_valid", 32'(inst_valid), 32'h0);
        chk("br_t1_req",   32'(imem.imem_req), 32'h1);
        chk("br_t1_addr",  imem.imem_addr, 32'h100);
        tick();
        chk("br_t2_valid", 32'(inst_valid), 32'h0);
        chk("br_t2_addr",  imem.imem_addr, 32'h104);
        tick();
        chk("br_t3_valid", 32'(inst_valid), 32'h1);
        chk("br_t3_instr", Instruction, word(32'h100));
        chk("br_t3_pc",    PC, 32'h104);
        tick();
        chk("br_t4_instr", Instruction, word(32'h104));

        // Two back-to-back redirects: the last target wins
        Br_taken = 1'b1; Br_addr = 32'h200;
        tick();
        chk("br2_req_gated", 32'(imem.imem_req), 32'h0);
        Br_addr = 32'h300;
        tick();
        Br_taken = 1'b0;
        #1;
        chk("br2_addr",  imem.imem_addr, 32'h300);
        chk("br2_valid", 32'(inst_valid), 32'h0);
        tick(); tick();
        chk("br2_instr", Instruction, word(32'h300));
        chk("br2_pc",    PC, 32'h304);

        // Grant pattern 1,0,0,1
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        imem.imem_gnt = 1'b0;
        chk("gn_addr1", imem.imem_addr, 32'h4);
        chk("gn_req1",  32'(imem.imem_req), 32'h1);
        tick();
        chk("gn_addr2",  imem.imem_addr, 32'h4);
        chk("gn_instr2", Instruction, word(32'h0));
        chk("gn_pc2",    PC, 32'h4);
        tick();
        imem.imem_gnt = 1'b1;
        chk("gn_addr3",  imem.imem_addr, 32'h4);
        chk("gn_valid3", 32'(inst_valid), 32'h0);
        tick();
        chk("gn_addr4", imem.imem_addr, 32'h8);
        tick();
        chk("gn_instr5", Instruction, word(32'h4));
        chk("gn_pc5",    PC, 32'h8);
        tick();
        chk("gn_instr6", Instruction, word(32'h8));

        // One-cycle reset pulse with a response pending
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(inst_valid), 32'h0);
        chk("mr_instr", Instruction, 32'h0);
        chk("mr_pc",    PC, 32'h0);
        chk("mr_req",   32'(imem.imem_req), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_addr",   imem.imem_addr, 32'h0);
        chk("mr_req_up", 32'(imem.imem_req), 32'h1);
        tick();
        chk("mr_no_stale", 32'(inst_valid), 32'h0);
        tick();
        chk("mr_instr0", Instruction, word(32'h0));
        chk("mr_pc0",    PC, 32'h4);

        // PC wrap through a redirect to the top word
        Br_taken = 1'b1; Br_addr = 32'hFFFF_FFFC;
        tick();
        Br_taken = 1'b0;
        #1;
        chk("wr_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_addr_zero", imem.imem_addr, 32'h0);
        tick();
        chk("wr_instr_top", Instruction, word(32'hFFFF_FFFC));
        chk("wr_pc_top",    PC, 32'h0);
        tick();
        chk("wr_instr_zero", Instruction, word(32'h0));
        chk("wr_pc_zero",    PC, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
